// File: rtl/serializer_8to1_seq_pkg.sv
// Shared widths, FSM encodings and select helper for the 8:1 frame serializer.
package serializer_8to1_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [SEL_W-1:0] LAST_IDX = 3'd7;

  // Mux select for a given beat index and bit order.
  function automatic logic [SEL_W-1:0] sel_of(input logic msb_first,
                                               input logic [SEL_W-1:0] cnt);
    return msb_first ? SEL_W'(LAST_IDX - cnt) : cnt;
  endfunction

endpackage

// File: rtl/serializer_8to1_seq_mux.sv
// 8:1 bit mux built from two 4:1 muxes and a final 2:1 stage on s2.
module mux_4x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  always_comb begin
    y = i0;
    case ({s1, s0})
      2'b00:   y = i0;
      2'b01:   y = i1;
      2'b10:   y = i2;
      default: y = i3;
    endcase
  end

endmodule

module mux_8x1_using_4x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic y
);

  logic w_lo;
  logic w_hi;

  mux_4x1 u_lo (.i0(i0), .i1(i1), .i2(i2), .i3(i3), .s0(s0), .s1(s1), .y(w_lo));
  mux_4x1 u_hi (.i0(i4), .i1(i5), .i2(i6), .i3(i7), .s0(s0), .s1(s1), .y(w_hi));

  assign y = s2 ? w_hi : w_lo;

endmodule

// File: rtl/serializer_8to1_seq.sv
// Parallel-to-serial frame sequencer: captures a byte on load handshake and
// walks the 8:1 mux select across all bit positions under downstream backpressure.
module serializer_8to1_seq
  import serializer_8to1_seq_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              sout,
  output logic              sout_valid,
  input  logic              sout_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              frame_done
);

  logic [0:0]        r_state;
  logic [SEL_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hold;

  logic [0:0]        w_state_nxt;
  logic [SEL_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_hold_nxt;
  logic              w_shift;
  logic              w_at_last;
  logic              w_load;
  logic              w_beat;
  logic              w_y;

  assign w_shift    = (r_state == ST_SHIFT);
  assign w_at_last  = (r_cnt == LAST_IDX);
  assign load_ready = (r_state == ST_IDLE) | (w_shift & w_at_last & sout_ready);
  assign w_load     = load_valid & load_ready;
  assign sout_valid = w_shift;
  assign w_beat     = sout_valid & sout_ready;
  assign frame_done = w_beat & w_at_last;
  assign busy       = w_shift;
  assign sel        = sel_of(MSB_FIRST, r_cnt);

  // State, beat counter and captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next state: a load can only land in IDLE or on the final accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    if (r_state == ST_IDLE) begin
      if (w_load) begin
        w_state_nxt = ST_SHIFT;
        w_cnt_nxt   = '0;
        w_hold_nxt  = din;
      end
    end else if (w_beat) begin
      if (!w_at_last) begin
        w_cnt_nxt = SEL_W'(r_cnt + SEL_W'(1));
      end else if (w_load) begin
        w_cnt_nxt  = '0;
        w_hold_nxt = din;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  mux_8x1_using_4x1 u_mux (
    .i0 (r_hold[0]),
    .i1 (r_hold[1]),
    .i2 (r_hold[2]),
    .i3 (r_hold[3]),
    .i4 (r_hold[4]),
    .i5 (r_hold[5]),
    .i6 (r_hold[6]),
    .i7 (r_hold[7]),
    .s0 (sel[0]),
    .s1 (sel[1]),
    .s2 (sel[2]),
    .y  (w_y)
  );

  // Serial output is quiet whenever no frame bit is presented.
  assign sout = w_y & sout_valid;

endmodule

// File: tb/tb_serializer_8to1_seq.sv
// Bench: LSB-first and MSB-first instances share stimulus; expected bits come from per-frame queues.
module tb_serializer_8to1_seq;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       load_valid;
  logic       sout_ready;

  logic       lr0, so0, sv0, bz0, fd0;
  logic [2:0] sel0;
  logic       lr1, so1, sv1, bz1, fd1;
  logic [2:0] sel1;

  int n_chk;
  int n_pass;

  bit q0[$];
  bit q1[$];
  int idle_idx;

  serializer_8to1_seq #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(lr0),
    .sout(so0), .sout_valid(sv0), .sout_ready(sout_ready), .sel(sel0),
    .busy(bz0), .frame_done(fd0)
  );

  serializer_8to1_seq #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(lr1),
    .sout(so1), .sout_valid(sv1), .sout_ready(sout_ready), .sel(sel1),
    .busy(bz1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Compare every output of both instances against the frame queues.
  task automatic check_all(input bit sr);
    int  n;
    bit  act;
    int  idx;
    bit  exp_lr;
    n      = q0.size();
    act    = (n != 0);
    idx    = act ? (8 - n) : idle_idx;
    exp_lr = (n == 0) || (n == 1 && sr);
    chk("sout_valid0", int'(sv0), int'(act));
    chk("sout_valid1", int'(sv1), int'(act));
    chk("sout0", int'(so0), act ? int'(q0[0]) : 0);
    chk("sout1", int'(so1), act ? int'(q1[0]) : 0);
    chk("sel0", int'(sel0), idx);
    chk("sel1", int'(sel1), 7 - idx);
    chk("busy0", int'(bz0), int'(act));
    chk("busy1", int'(bz1), int'(act));
    chk("load_ready0", int'(lr0), int'(exp_lr));
    chk("load_ready1", int'(lr1), int'(exp_lr));
    chk("frame_done0", int'(fd0), int'(n == 1 && sr));
    chk("frame_done1", int'(fd1), int'(n == 1 && sr));
  endtask

  // One clock: drive, check mid-cycle, then advance the reference after the edge.
  task automatic step(input bit lv, input logic [7:0] d, input bit sr);
    bit ld;
    bit bt;
    bit lr;
    int n;
    load_valid = lv;
    din        = d;
    sout_ready = sr;
    @(negedge clk);
    check_all(sr);
    n  = q0.size();
    lr = (n == 0) || (n == 1 && sr);
    ld = lv && lr && !rst;
    bt = (n != 0) && sr && !rst;
    @(posedge clk);
    #1;
    if (bt) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      if (n == 1) idle_idx = 7;
    end
    if (ld) begin
      for (int k = 0; k < 8; k++) q0.push_back(d[k]);
      for (int k = 7; k >= 0; k--) q1.push_back(d[k]);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    idle_idx   = 0;
    rst        = 1'b1;
    din        = 8'h00;
    load_valid = 1'b0;
    sout_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset: load_valid during reset must not capture.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b1);

    // Plain frames in both bit orders.
    step(1'b1, 8'hA5, 1'b1);
    drain();
    step(1'b1, 8'h81, 1'b1);
    drain();

    // Stall for 4 cycles at bit index 3.
    step(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
    drain();

    // Back-to-back frames with load_valid held high.
    step(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h00, 1'b1);
    drain();

    // Asynchronous reset mid-frame, then a fresh load.
    step(1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_sout_valid0", int'(sv0), 0);
    chk("rst_sout_valid1", int'(sv1), 0);
    chk("rst_sout0", int'(so0), 0);
    chk("rst_sout1", int'(so1), 0);
    q0.delete();
    q1.delete();
    idle_idx = 0;
    step(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    step(1'b1, 8'h0F, 1'b1);
    drain();

    // Load attempts mid-frame are ignored.
    step(1'b1, 8'h96, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
